// File: rtl/lif_tdm_scheduler.sv
// lif_tdm_scheduler: one leaky-integrate-and-fire datapath shared across
// N_NEURONS virtual neurons. A tick starts a sweep that updates every neuron
// once; each spike is emitted as an event over a valid/ready handshake.
// Optional build macro: LIF_OVERRUN_CNT_EN adds o_overrun_cnt, a saturating
// count of ticks received while busy and of currents offered while not ready.
module lif_tdm_scheduler #(
   parameter  int N_NEURONS = 8,
   parameter  int STATE_W   = 6,
   parameter  int THRESHOLD = 32,
   localparam int IDW       = $clog2(N_NEURONS)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_cur_valid,
   output logic               o_cur_ready,
   input  logic [IDW-1:0]     i_cur_id,
   input  logic [STATE_W-1:0] i_cur_value,
   input  logic               i_tick_start,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_spike_valid,
   input  logic               i_spike_ready,
   output logic [IDW-1:0]     o_spike_id,
   input  logic               i_thr_wr_en,
   input  logic [STATE_W-1:0] i_thr_wr_data
`ifdef LIF_OVERRUN_CNT_EN
   ,
   output logic [7:0]         o_overrun_cnt
`endif
);

   localparam logic [STATE_W-1:0] THR_RST  = STATE_W'(THRESHOLD);
   localparam logic [IDW-1:0]     IDX_LAST = IDW'(N_NEURONS - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SWEEP = 2'd1,
      S_EMIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Unsigned add that clamps at the all-ones value instead of wrapping.
   function automatic logic [STATE_W-1:0] sat_add(input logic [STATE_W-1:0] a,
                                                  input logic [STATE_W-1:0] b);
      logic [STATE_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum[STATE_W]) begin
         return {STATE_W{1'b1}};
      end else begin
         return sum[STATE_W-1:0];
      end
   endfunction

   state_t             r_fsm;
   logic [IDW-1:0]     r_idx;
   logic [STATE_W-1:0] r_thr;
   logic [STATE_W-1:0] r_acc    [N_NEURONS];
   logic [STATE_W-1:0] r_state  [N_NEURONS];
   logic               r_spiked [N_NEURONS];

   logic [STATE_W-1:0] w_leak;
   logic [STATE_W-1:0] w_next;
   logic               w_spike;
   logic               w_last;
   logic [STATE_W-1:0] w_cur_sum;

   // Neuron update for the index under the sweep, plus the accumulator update.
   always_comb begin
      w_leak    = {STATE_W{1'b0}};
      w_next    = {STATE_W{1'b0}};
      w_spike   = 1'b0;
      w_last    = 1'b0;
      w_cur_sum = {STATE_W{1'b0}};
      // A neuron that fired last step restarts from zero: no leak carried over.
      if (r_spiked[r_idx]) begin
         w_leak = {STATE_W{1'b0}};
      end else begin
         w_leak = r_state[r_idx] >> 1;
      end
      w_next    = sat_add(r_acc[r_idx], w_leak);
      w_spike   = (w_next >= r_thr);
      w_last    = (r_idx == IDX_LAST);
      w_cur_sum = sat_add(r_acc[i_cur_id], i_cur_value);
   end

   // Sweep FSM, neuron arrays, threshold and all registered handshake outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_fsm         <= S_IDLE;
         r_idx         <= {IDW{1'b0}};
         r_thr         <= THR_RST;
         o_cur_ready   <= 1'b1;
         o_busy        <= 1'b0;
         o_done        <= 1'b0;
         o_spike_valid <= 1'b0;
         o_spike_id    <= {IDW{1'b0}};
         for (int i = 0; i < N_NEURONS; i++) begin
            r_acc[i]    <= {STATE_W{1'b0}};
            r_state[i]  <= {STATE_W{1'b0}};
            r_spiked[i] <= 1'b0;
         end
      end else begin
         o_done <= 1'b0;
         case (r_fsm)
            S_IDLE: begin
               // A current accepted together with the tick lands before the sweep reads it.
               if (i_cur_valid && o_cur_ready) begin
                  r_acc[i_cur_id] <= w_cur_sum;
               end
               if (i_thr_wr_en) begin
                  r_thr <= i_thr_wr_data;
               end
               if (i_tick_start) begin
                  r_fsm       <= S_SWEEP;
                  r_idx       <= {IDW{1'b0}};
                  o_cur_ready <= 1'b0;
                  o_busy      <= 1'b1;
               end
            end
            S_SWEEP: begin
               r_state[r_idx]  <= w_next;
               r_spiked[r_idx] <= w_spike;
               r_acc[r_idx]    <= {STATE_W{1'b0}};
               if (w_spike) begin
                  r_fsm         <= S_EMIT;
                  o_spike_valid <= 1'b1;
                  o_spike_id    <= r_idx;
               end else if (w_last) begin
                  r_fsm  <= S_DONE;
                  o_done <= 1'b1;
               end else begin
                  r_idx <= r_idx + IDW'(1);
               end
            end
            S_EMIT: begin
               // Event stays valid with a stable id until the consumer takes it.
               if (i_spike_ready) begin
                  o_spike_valid <= 1'b0;
                  if (w_last) begin
                     r_fsm  <= S_DONE;
                     o_done <= 1'b1;
                  end else begin
                     r_fsm <= S_SWEEP;
                     r_idx <= r_idx + IDW'(1);
                  end
               end
            end
            S_DONE: begin
               r_fsm       <= S_IDLE;
               o_busy      <= 1'b0;
               o_cur_ready <= 1'b1;
            end
            default: begin
               r_fsm         <= S_IDLE;
               r_idx         <= {IDW{1'b0}};
               o_cur_ready   <= 1'b1;
               o_busy        <= 1'b0;
               o_spike_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef LIF_OVERRUN_CNT_EN
   logic [1:0] w_ovr_inc;
   logic [8:0] w_ovr_sum;

   // Number of overrun events this cycle and the unclamped new count.
   always_comb begin
      w_ovr_inc = 2'd0;
      w_ovr_sum = 9'd0;
      w_ovr_inc = {1'b0, (i_tick_start & o_busy)} + {1'b0, (i_cur_valid & ~o_cur_ready)};
      w_ovr_sum = {1'b0, o_overrun_cnt} + {7'd0, w_ovr_inc};
   end

   // Saturating overrun counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         o_overrun_cnt <= 8'd0;
      end else if (w_ovr_sum > 9'd255) begin
         o_overrun_cnt <= 8'hFF;
      end else begin
         o_overrun_cnt <= w_ovr_sum[7:0];
      end
   end
`else
   // Without the counter, ticks while busy and currents offered while not
   // ready are simply dropped.
`endif

endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// Directed bench for lif_tdm_scheduler with a spike/done scoreboard.
// Honors LIF_OVERRUN_CNT_EN when the design is built with it.
module tb_lif_tdm_scheduler;
   localparam int N   = 8;
   localparam int SW  = 6;
   localparam int IDW = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          i_cur_valid;
   logic          o_cur_ready;
   logic [IDW-1:0] i_cur_id;
   logic [SW-1:0] i_cur_value;
   logic          i_tick_start;
   logic          o_busy;
   logic          o_done;
   logic          o_spike_valid;
   logic          i_spike_ready;
   logic [IDW-1:0] o_spike_id;
   logic          i_thr_wr_en;
   logic [SW-1:0] i_thr_wr_data;
`ifdef LIF_OVERRUN_CNT_EN
   logic [7:0]    o_overrun_cnt;
`endif

   lif_tdm_scheduler #(.N_NEURONS(N), .STATE_W(SW), .THRESHOLD(32)) dut (
      .clk           (clk),
      .reset         (reset),
      .i_cur_valid   (i_cur_valid),
      .o_cur_ready   (o_cur_ready),
      .i_cur_id      (i_cur_id),
      .i_cur_value   (i_cur_value),
      .i_tick_start  (i_tick_start),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_spike_valid (o_spike_valid),
      .i_spike_ready (i_spike_ready),
      .o_spike_id    (o_spike_id),
      .i_thr_wr_en   (i_thr_wr_en),
      .i_thr_wr_data (i_thr_wr_data)
`ifdef LIF_OVERRUN_CNT_EN
      ,
      .o_overrun_cnt (o_overrun_cnt)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   // Cycle counter: value is stable between rising edges.
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp  = 0;
   int n_fail = 0;
   int exp_spike[$];
   int exp_done[$];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic inject(input int id, input int val);
      i_cur_valid = 1'b1;
      i_cur_id    = IDW'(id);
      i_cur_value = SW'(val);
      step();
      i_cur_valid = 1'b0;
   endtask

   // Issues a tick; returns the cycle in which the tick was sampled.
   task automatic tick(output int t);
      t = cyc;
      i_tick_start = 1'b1;
      step();
      i_tick_start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int k;
      k = 0;
      while (!(o_cur_ready && !o_busy) && k < 200) begin
         step();
         k++;
      end
      chk({name, "_idle_timeout"}, int'(k < 200), 1);
   endtask

   initial begin
      int t;
      reset = 1'b1; i_cur_valid = 1'b0; i_cur_id = '0; i_cur_value = '0;
      i_tick_start = 1'b0; i_spike_ready = 1'b1; i_thr_wr_en = 1'b0; i_thr_wr_data = '0;

      // Monitor: pops the scoreboard on every spike handshake and done pulse.
      fork
         forever begin
            @(negedge clk);
            if (!reset) begin
               if (o_spike_valid && i_spike_ready) begin
                  if (exp_spike.size() == 0) begin
                     chk("spike_unexpected", int'(o_spike_id), -1);
                  end else begin
                     chk("spike_id", int'(o_spike_id), exp_spike.pop_front());
                  end
               end
               if (o_done) begin
                  if (exp_done.size() == 0) begin
                     chk("done_unexpected", cyc, -1);
                  end else begin
                     chk("done_cycle", cyc, exp_done.pop_front());
                  end
               end
            end
         end
      join_none

      repeat (3) step();
      reset = 1'b0;
      chk("rst_cur_ready", int'(o_cur_ready), 1);
      chk("rst_busy", int'(o_busy), 0);
      chk("rst_done", int'(o_done), 0);
      chk("rst_spike_valid", int'(o_spike_valid), 0);
      chk("rst_spike_id", int'(o_spike_id), 0);
      chk("rst_thr", int'(dut.r_thr), 32);

      // Single spike on neuron 3, then reset-on-spike.
      inject(3, 40);
      exp_spike.push_back(3);
      tick(t); exp_done.push_back(t + 10);
      wait_idle("t1a");
      chk("t1_state3", int'(dut.r_state[3]), 40);
      tick(t); exp_done.push_back(t + 9);
      wait_idle("t1b");
      chk("t1_state3_reset", int'(dut.r_state[3]), 0);

      // Leak of one half per timestep.
      inject(0, 20);
      tick(t); exp_done.push_back(t + 9); wait_idle("lk1");
      chk("leak_20", int'(dut.r_state[0]), 20);
      tick(t); exp_done.push_back(t + 9); wait_idle("lk2");
      chk("leak_10", int'(dut.r_state[0]), 10);
      tick(t); exp_done.push_back(t + 9); wait_idle("lk3");
      chk("leak_5", int'(dut.r_state[0]), 5);
      tick(t); exp_done.push_back(t + 9); wait_idle("lk4");
      chk("leak_2", int'(dut.r_state[0]), 2);

      // Saturating accumulate: 50 + 50 clamps at 63.
      inject(1, 50);
      inject(1, 50);
      chk("sat_acc1", int'(dut.r_acc[1]), 63);
      exp_spike.push_back(1);
      tick(t); exp_done.push_back(t + 10); wait_idle("sat");
      chk("sat_state1", int'(dut.r_state[1]), 63);

      // Backpressure: spike on 2 stalled five cycles, then 5.
      inject(2, 40);
      inject(5, 40);
      i_spike_ready = 1'b0;
      exp_spike.push_back(2);
      exp_spike.push_back(5);
      tick(t); exp_done.push_back(t + 16);
      repeat (3) step();
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid_held", int'(o_spike_valid), 1);
         chk("bp_id_stable", int'(o_spike_id), 2);
         step();
      end
      i_spike_ready = 1'b1;
      step();
      chk("bp_valid_drop", int'(o_spike_valid), 0);
      wait_idle("bp");

      // Threshold write in IDLE honoured, write and tick while busy ignored.
      i_thr_wr_en = 1'b1; i_thr_wr_data = 6'd10;
      step();
      i_thr_wr_en = 1'b0;
      chk("thr_write", int'(dut.r_thr), 10);
      inject(7, 12);
      exp_spike.push_back(7);
      tick(t); exp_done.push_back(t + 10);
      i_thr_wr_en = 1'b1; i_thr_wr_data = 6'd60; i_tick_start = 1'b1;
      step();
      i_thr_wr_en = 1'b0; i_tick_start = 1'b0;
      wait_idle("thr");
      chk("thr_busy_ignored", int'(dut.r_thr), 10);
`ifdef LIF_OVERRUN_CNT_EN
      chk("overrun_cnt", int'(o_overrun_cnt), 1);
`endif
      repeat (3) step();
      chk("busy_tick_ignored", int'(o_busy), 0);

      // Reset in the middle of an EMIT handshake.
      inject(4, 40);
      i_spike_ready = 1'b0;
      exp_spike.push_back(4);
      tick(t); exp_done.push_back(t + 10);
      repeat (5) step();
      chk("rstemit_valid", int'(o_spike_valid), 1);
      chk("rstemit_id", int'(o_spike_id), 4);
      reset = 1'b1;
      exp_spike.delete();
      exp_done.delete();
      step();
      chk("rstemit_valid_clr", int'(o_spike_valid), 0);
      chk("rstemit_busy", int'(o_busy), 0);
      chk("rstemit_cur_ready", int'(o_cur_ready), 1);
      chk("rstemit_thr", int'(dut.r_thr), 32);
      for (int i = 0; i < N; i++) begin
         chk("rstemit_state", int'(dut.r_state[i]), 0);
         chk("rstemit_acc", int'(dut.r_acc[i]), 0);
      end
`ifdef LIF_OVERRUN_CNT_EN
      chk("rstemit_overrun", int'(o_overrun_cnt), 0);
`endif
      reset = 1'b0;
      i_spike_ready = 1'b1;
      step();

      // Back at threshold 32: 33 on neuron 6 fires, 31 on neuron 0 does not.
      inject(6, 33);
      inject(0, 31);
      exp_spike.push_back(6);
      tick(t); exp_done.push_back(t + 10);
      wait_idle("post");
      chk("post_state0", int'(dut.r_state[0]), 31);
      chk("post_state6", int'(dut.r_state[6]), 33);

      repeat (4) step();
      chk("spike_queue_empty", exp_spike.size(), 0);
      chk("done_queue_empty", exp_done.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/lif_tdm_scheduler.md
Name: lif_tdm_scheduler

Overview:
Time-multiplexes one leaky-integrate-and-fire update datapath across N_NEURONS virtual neurons. Per-neuron input current accumulators, membrane states and spike flags are held in internal register arrays. Each timestep is a sequential sweep started by a tick: every neuron is updated once, and each spike is emitted as an event over a valid/ready handshake. Sits between the stimulus/input interface and the spike-event consumer (router or output port).

Parameters:
N_NEURONS, 8, number of virtual neurons; power of two, at least 2.
STATE_W, 6, width of current, accumulator, state and threshold.
THRESHOLD, 32, reset value of the firing threshold register.
IDW, $clog2(N_NEURONS), neuron index width (derived).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cur_valid  in  1  input current present
cur_ready  out  1  scheduler accepts current; high only in IDLE
cur_id  in  IDW  target neuron
cur_value  in  STATE_W  current to add
tick_start  in  1  start one timestep sweep
busy  out  1  high in SWEEP, EMIT and DONE
done  out  1  one-cycle pulse at end of sweep
spike_valid  out  1  spike event present
spike_ready  in  1  consumer accepts event
spike_id  out  IDW  index of spiking neuron
thr_wr_en  in  1  write threshold; honoured in IDLE only
thr_wr_data  in  STATE_W  new threshold

Behaviour:
- Reset (synchronous, active-high; clock clk): FSM to IDLE, index 0. All acc, state and spiked entries clear to 0. Threshold loads THRESHOLD. Outputs: cur_ready=1, busy=0, done=0, spike_valid=0, spike_id=0. Reset overrides any mid-sweep or mid-handshake activity; a pending event is dropped.
- FSM states: IDLE, SWEEP, EMIT, DONE.
- IDLE:
  - cur_valid&cur_ready updates acc[cur_id] <= sat(acc[cur_id]+cur_value), saturating at 2^STATE_W-1.
  - thr_wr_en loads the threshold.
  - tick_start moves to SWEEP with idx=0. A current accepted in the same cycle is included in this sweep.
- tick_start outside IDLE is ignored. thr_wr_en outside IDLE is ignored.
- SWEEP, one neuron per cycle at idx:
  - n = sat(acc[idx] + (spiked[idx] ? 0 : state[idx]>>1)); state is reset-on-spike with a leak of 1/2.
  - s = (n >= threshold).
  - Commit state[idx]<=n, spiked[idx]<=s, acc[idx]<=0.
  - If s, go to EMIT with spike_id<=idx.
  - Else, if idx==N_NEURONS-1 go to DONE, otherwise idx+1.
- EMIT: spike_valid=1 with spike_id held stable until the cycle spike_valid&spike_ready. Then resume SWEEP at idx+1, or go to DONE if idx was last. spike_valid deasserts the cycle after the handshake.
- DONE: done=1 for one cycle, then IDLE.
- Latency without spikes: tick in cycle T; SWEEP in T+1..T+N; done in T+N+1; cur_ready high in T+N+2. Each spike adds at least 1 EMIT cycle.
- Arithmetic is unsigned STATE_W-bit with saturation; no wrap-around anywhere.

Optional Feature:
LIF_OVERRUN_CNT_EN
- Defined: adds output overrun_cnt [7:0], reset to 0. It increments, saturating at 255, on every tick_start received while busy=1, and on every cycle with cur_valid=1 and cur_ready=0.
- Undefined: no port and no counter; such events are silently ignored.

Test Plan:
- Reset, then N=8, threshold 32, inject 40 to neuron 3, tick -> one event spike_id=3, state[3]=40, done at T+10. Second tick without input -> state[3]=0, no event.
- Leak: inject 20 to neuron 0, then ticks with no input -> state[0] goes 20, 10, 5, 2; no spikes.
- Saturation: inject 50 twice to neuron 1 -> acc=63. Tick -> spike_id=1, state[1]=63.
- Backpressure: neurons 2 and 5 spike, spike_ready low for 5 cycles -> spike_valid held, spike_id=2 stable. Then ids 2 then 5 in order; done delayed by the stall.
- Threshold write 10 in IDLE, and write 60 while busy (ignored): inject 12 to neuron 7 -> spike_id=7. Also tick while busy -> ignored; with LIF_OVERRUN_CNT_EN, overrun_cnt=1.
- Assert reset during EMIT -> next cycle spike_valid=0, busy=0, cur_ready=1, all state 0, threshold 32.
